// File: rtl/dom_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dom_pkg
// Description : Shared helpers for the DOM-indep masked multiplier.
//               - nrnd()       : number of fresh random words for order d
//               - pair_idx()   : randomness index shared by domains i and j
//               - share_base() : bit offset of share i in a packed vector
// Revision    : 1.0 - initial release
// ============================================================================
package dom_pkg;

    // Smallest masking order the gadget is defined for. With order 0 there are
    // no cross-domain terms and no randomness bus.
    localparam int MIN_ORDER = 1;

    // One random word per unordered domain pair.
    function automatic int nrnd(input int order);
        return order * (order + 1) / 2;
    endfunction

    // Pairs are numbered row-major over the upper triangle (i < j), so
    // pair (j,i) maps onto the same word as (i,j). This reuse is what lets
    // each random word appear once in each of the two domains and cancel
    // when the output shares are recombined.
    function automatic int pair_idx(input int i, input int j, input int shares);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    // Low bit of share i when shares of 'width' bits are packed LSB first.
    function automatic int share_base(input int i, input int width);
        return i * width;
    endfunction

endpackage : dom_pkg
`default_nettype wire

// File: rtl/dom_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dom_stage_reg
// Description : One valid/ready pipeline stage: a DW-bit data register plus
//               a valid flag. Loads when upstream offers data and the stage
//               can take it, holds while stalled, clears on reset.
// Ports       : clk, rst             - clock / synchronous active-high reset
//               in_valid_i           - upstream offers in_data_i
//               in_ready_o           - stage can take data this cycle
//               in_data_i  [DW]      - data to capture
//               out_valid_o          - out_data_o holds a valid item
//               out_ready_i          - downstream consumes out_data_o
//               out_data_o [DW]      - registered data
// Revision    : 1.0 - initial release
// ============================================================================
module dom_stage_reg
    import dom_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          load_w;

    // Empty, or being drained this cycle: a full stage can take a new item in
    // the same cycle its current one leaves, so there is no bubble.
    assign in_ready_o = ~valid_q | out_ready_i;
    assign load_w     = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_w) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Data only changes on a load: the whole word is captured at once, and a
    // drained stage keeps its old contents rather than being zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule : dom_stage_reg
`default_nettype wire

// File: rtl/dom_indep_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dom_indep_mul_pipe
// Description : DOM-indep masked AND of order ORDER over WIDTH-bit lanes.
//               Stage 1 registers every inner term a_i&b_i and every blinded
//               cross term (a_i&b_j)^r_k(i,j). Output share i is the XOR of
//               row i of those registers.
//               Build option DOM_OUT_REG_EN: adds a second stage that
//               registers the compressed shares so port_c comes straight from
//               flops (latency 2). Without it the latency is 1.
// Ports       : clk, rst               - clock / synchronous active-high reset
//               in_valid, in_ready     - operand handshake
//               port_a, port_b         - SHARES*WIDTH, share i at [i*WIDTH +: WIDTH]
//               port_r                 - NRND*WIDTH fresh randomness
//               out_valid, out_ready   - result handshake
//               port_c                 - SHARES*WIDTH product shares
// Revision    : 1.0 - initial release
// ============================================================================
module dom_indep_mul_pipe
    import dom_pkg::*;
#(
    parameter int ORDER = 1,   // masking order, must be >= MIN_ORDER
    parameter int WIDTH = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [(ORDER+1)*WIDTH-1:0]              port_a,
    input  logic [(ORDER+1)*WIDTH-1:0]              port_b,
    input  logic [(ORDER*(ORDER+1)/2)*WIDTH-1:0]    port_r,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [(ORDER+1)*WIDTH-1:0]              port_c
);

    localparam int SHARES = ORDER + 1;
    localparam int NRND   = nrnd(ORDER);
    // Full SHARES x SHARES term matrix; entry (i,j) sits at (i*SHARES+j)*WIDTH.
    // Diagonal entries are the inner terms, off-diagonal the cross terms.
    localparam int TW     = SHARES * SHARES * WIDTH;

    logic [NRND*WIDTH-1:0]   rnd_w;
    logic [TW-1:0]           term_d;
    logic [TW-1:0]           term_q;
    logic [SHARES*WIDTH-1:0] comp_w;
    logic                    s1_valid_w;
    logic                    s1_out_ready_w;

    assign rnd_w = port_r;

    // ------------------------------------------------------------------------
    // Term generation
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            localparam int T  = (i * SHARES + j) * WIDTH;
            localparam int AI = share_base(i, WIDTH);
            localparam int BJ = share_base(j, WIDTH);
            if (i == j) begin : g_inner
                assign term_d[T +: WIDTH] = port_a[AI +: WIDTH] & port_b[BJ +: WIDTH];
            end else begin : g_cross
                // (i,j) and (j,i) pick the same random word, once per domain.
                localparam int K = pair_idx(i, j, SHARES);
                assign term_d[T +: WIDTH] = (port_a[AI +: WIDTH] & port_b[BJ +: WIDTH])
                                          ^ rnd_w[K*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: all terms registered together so no unblinded cross product
    // ever reaches the compression XOR combinationally.
    // ------------------------------------------------------------------------
    dom_stage_reg #(
        .DW (TW)
    ) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (term_d),
        .out_valid_o (s1_valid_w),
        .out_ready_i (s1_out_ready_w),
        .out_data_o  (term_q)
    );

    // ------------------------------------------------------------------------
    // Compression: each output share only ever touches its own domain's row.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < SHARES; i++) begin : g_comp
        logic [WIDTH-1:0] acc;
        always_comb begin
            acc = '0;
            for (int j = 0; j < SHARES; j++) begin
                acc = acc ^ term_q[(i*SHARES + j)*WIDTH +: WIDTH];
            end
        end
        assign comp_w[share_base(i, WIDTH) +: WIDTH] = acc;
    end

    // ------------------------------------------------------------------------
    // Output
    // ------------------------------------------------------------------------
`ifdef DOM_OUT_REG_EN
    // Second stage isolates downstream gadgets from glitches on the XOR tree.
    // Its ready feeds stage 1, so the backpressure rule holds per stage.
    dom_stage_reg #(
        .DW (SHARES*WIDTH)
    ) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid_w),
        .in_ready_o  (s1_out_ready_w),
        .in_data_i   (comp_w),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (port_c)
    );
`else
    assign s1_out_ready_w = out_ready;
    assign out_valid      = s1_valid_w;
    assign port_c         = comp_w;
`endif

endmodule : dom_indep_mul_pipe
`default_nettype wire

// File: tb/tb_dom_indep_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dom_indep_mul_pipe
// Description : Directed bench for dom_indep_mul_pipe. One ORDER=1/WIDTH=1
//               instance for hand-computed share vectors and handshake corner
//               cases, one ORDER=2/WIDTH=4 instance streamed at full rate and
//               checked on the recombined product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dom_indep_mul_pipe;

`ifdef DOM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ORDER=1, WIDTH=1 instance
    logic       iv1, ir1, ov1, or1;
    logic [1:0] a1, b1, c1;
    logic [0:0] r1;

    // ORDER=2, WIDTH=4 instance
    logic        iv2, ir2, ov2, or2;
    logic [11:0] a2, b2, c2, r2;

    dom_indep_mul_pipe #(.ORDER(1), .WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .port_a(a1), .port_b(b1), .port_r(r1),
        .out_valid(ov1), .out_ready(or1), .port_c(c1)
    );

    dom_indep_mul_pipe #(.ORDER(2), .WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .port_a(a2), .port_b(b2), .port_r(r2),
        .out_valid(ov2), .out_ready(or2), .port_c(c2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] unshare3(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       r;
        logic [1:0] c;   // {c1, c0}
    } vec_t;

    vec_t tbl [7];

    task automatic drive1(input vec_t v);
        a1 = v.a;
        b1 = v.b;
        r1 = v.r;
    endtask

    // Hard stop in case the design never answers.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  expq [$];
        logic [1:0]  got  [$];
        logic [3:0]  xa, xb, s0, s1;
        logic [2:0]  vseq;
        logic        acc2;
        logic        exp_v;
        int          n_acc;

        // c0 = a0b0 ^ a0b1 ^ r ; c1 = a1b1 ^ a1b0 ^ r
        tbl[0] = '{a: 2'b01, b: 2'b10, r: 1'b1, c: 2'b10};
        tbl[1] = '{a: 2'b11, b: 2'b11, r: 1'b0, c: 2'b00};
        tbl[2] = '{a: 2'b11, b: 2'b11, r: 1'b1, c: 2'b11};
        tbl[3] = '{a: 2'b10, b: 2'b01, r: 1'b0, c: 2'b10};
        tbl[4] = '{a: 2'b00, b: 2'b11, r: 1'b1, c: 2'b11};
        tbl[5] = '{a: 2'b01, b: 2'b01, r: 1'b0, c: 2'b01};
        tbl[6] = '{a: 2'b10, b: 2'b10, r: 1'b1, c: 2'b01};

        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; r1 = '0;
        iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; r2 = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 32'(ov1), 32'd0);
        check("rst port_c",    32'(c1),  32'd0);
        check("rst out_valid2", 32'(ov2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst in_ready", 32'(ir1), 32'd1);

        // ---------------- table vectors, one at a time ----------------
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive1(tbl[i]);
            iv1 = 1'b1;
            @(posedge clk); #1;
            iv1 = 1'b0;
            for (int k = 1; k < LAT; k++) begin
                @(posedge clk); #1;
            end
            check($sformatf("vec%0d out_valid", i), 32'(ov1), 32'd1);
            check($sformatf("vec%0d port_c", i),    32'(c1),  32'(tbl[i].c));
        end
        @(posedge clk); #1;
        check("drain out_valid", 32'(ov1), 32'd0);

        // ---------------- ORDER=2 full-throughput stream ----------------
        n_acc = 0;
        for (int n = 0; n < 1000 + LAT + 2; n++) begin
            @(negedge clk);
            if (n < 1000) begin
                if (n < 500) begin
                    xa = 4'hC;
                    xb = 4'hA;
                end else begin
                    xa = 4'($urandom);
                    xb = 4'($urandom);
                end
                s0 = 4'($urandom);
                s1 = 4'($urandom);
                a2 = {xa ^ s0 ^ s1, s1, s0};
                s0 = 4'($urandom);
                s1 = 4'($urandom);
                b2 = {xb ^ s0 ^ s1, s1, s0};
                r2 = 12'($urandom);
                iv2 = 1'b1;
                if (ir2) begin
                    expq.push_back(xa & xb);
                    n_acc++;
                end
            end else begin
                iv2 = 1'b0;
            end
            @(posedge clk); #1;
            if (ov2) begin
                if (expq.size() == 0) begin
                    check("stream extra result", 32'd1, 32'd0);
                end else begin
                    check("stream product", 32'(unshare3(c2)), 32'(expq.pop_front()));
                end
            end
        end
        check("stream accepted", 32'(n_acc), 32'd1000);
        check("stream left over", 32'(expq.size()), 32'd0);

        // ---------------- backpressure ----------------
        @(negedge clk);
        or1 = 1'b0;
        drive1(tbl[0]);
        iv1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        drive1(tbl[2]);
        iv1  = 1'b1;
        acc2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (iv1 && ir1) acc2 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("stall%0d out_valid", k), 32'(ov1), 32'd1);
            check($sformatf("stall%0d port_c", k),    32'(c1),  32'(tbl[0].c));
            check($sformatf("stall%0d in_ready", k),  32'(ir1), 32'd0);
            @(negedge clk);
            iv1 = !acc2;
        end
        or1 = 1'b1;
        #1;
        check("release in_ready", 32'(ir1), 32'd1);
        if (iv1 && ir1) acc2 = 1'b1;
        @(posedge clk); #1;
        check("release out_valid", 32'(ov1),  32'd1);
        check("release port_c",    32'(c1),   32'(tbl[2].c));
        check("release accepted",  32'(acc2), 32'd1);
        @(negedge clk);
        iv1 = 1'b0;
        @(posedge clk); #1;
        check("release drained", 32'(ov1), 32'd0);

        // ---------------- reset while stalled ----------------
        @(negedge clk);
        or1 = 1'b0;
        drive1(tbl[6]);
        iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk); #1;
        end
        check("pre-rst out_valid", 32'(ov1), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid-rst out_valid", 32'(ov1), 32'd0);
        check("mid-rst port_c",    32'(c1),  32'd0);
        check("mid-rst in_ready",  32'(ir1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        or1 = 1'b1;

        // ---------------- bubble: in_valid 1,0,1 ----------------
        vseq = 3'b101;   // bit e-1 is the in_valid of edge e
        for (int e = 1; e <= 3 + LAT; e++) begin
            @(negedge clk);
            if (e <= 3) begin
                if (e == 1) drive1(tbl[4]);
                else        drive1(tbl[5]);
                iv1 = vseq[e-1];
            end else begin
                iv1 = 1'b0;
            end
            @(posedge clk); #1;
            exp_v = (e - LAT >= 0 && e - LAT < 3) ? vseq[e-LAT] : 1'b0;
            check($sformatf("bubble e%0d out_valid", e), 32'(ov1), 32'(exp_v));
            if (ov1) got.push_back(c1);
        end
        check("bubble count", 32'(got.size()), 32'd2);
        if (got.size() >= 2) begin
            check("bubble first",  32'(got[0]), 32'(tbl[4].c));
            check("bubble second", 32'(got[1]), 32'(tbl[5].c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_dom_indep_mul_pipe
`default_nettype wire
